// File: rtl/ps2_scancode_fifo.sv
// PS/2 keyboard receiver: deframes bytes, folds E0/F0 prefixes into flags and
// queues {extended, release, code} key events in a show-ahead FIFO.
module ps2_scancode_fifo #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]    clk_sync_q, data_sync_q, clk_hist_q;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    mem_q [FIFO_DEPTH];

  logic       fall, din, push, pop, full, do_push;
  logic [9:0] push_data, head;

  // Newest synced sample is clk_sync_q[1]; clk_hist_q holds the two before it.
  assign fall = clk_hist_q[1] & ~clk_hist_q[0] & ~clk_sync_q[1];
  assign din  = data_sync_q[1];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    tmo_d       = tmo_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_data   = {ext_q, rel_q, shift_q};
    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!din) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            rel_d       = 1'b0;
          end
        end
        StData: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = ^{shift_q, din};
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (din && par_ok_q) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              rel_d = 1'b1;
            end else begin
              push  = 1'b1;
              ext_d = 1'b0;
              rel_d = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            rel_d       = 1'b0;
          end
        end
      endcase
    end else if (state_q != StIdle) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d     = StIdle;
        frame_err_d = 1'b1;
        ext_d       = 1'b0;
        rel_d       = 1'b0;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO survives it.
  assign pop     = key_valid & key_ready;
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign do_push = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
    case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_hist_q  <= 2'b11;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_hist_q  <= {clk_hist_q[0], clk_sync_q[1]};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head         = mem_q[rd_ptr_q];
  assign key_valid    = (cnt_q != '0);
  assign key_code     = key_valid ? head[7:0] : 8'h00;
  assign key_extended = key_valid & head[9];
  assign key_release  = key_valid & head[8];
  assign overflow     = overflow_q;
  assign frame_err    = frame_err_q;

endmodule
